// File: rtl/walk_sched_pkg.sv
// rtl/walk_sched_pkg.sv - shared types and defaults for the walk request scheduler
// Purpose: scheduler state encoding, default timing constants and a small
//          helper used to size the shared timer.
package walk_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    RUN       = 3'd3,
    GAP       = 3'd4
  } state_t;

  localparam int DEF_BUSY_TIMEOUT = 8;
  localparam int DEF_GAP_CYCLES   = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick over a pending vector
// Purpose: choose the first pending requester after the pointer, wrapping.
// Ports:
//   i_pending  N_REQ bits   requests eligible for a grant
//   i_ptr      IW bits      last winner; search starts one past it
//   o_grant    N_REQ bits   one-hot winner (zero when nothing pending)
//   o_idx      IW bits      binary winner index
//   o_any      1 bit        any requester pending
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_pending,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]         o_grant,
  output logic [$clog2(N_REQ)-1:0] o_idx,
  output logic                     o_any
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] cand;

  // Walk ptr+1 .. ptr+N_REQ (mod N_REQ); the first hit is latched by o_any.
  always_comb begin
    cand    = '0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(i_ptr) + k) % N_REQ);
      if (!o_any && i_pending[cand]) begin
        o_any         = 1'b1;
        o_grant[cand] = 1'b1;
        o_idx         = cand;
      end
    end
  end

endmodule

// File: rtl/walk_req_scheduler.sv
// rtl/walk_req_scheduler.sv - round-robin sharing of one LED walker between buttons
// Purpose: synchronise and edge-detect raw buttons, latch pending requests,
//          grant them one at a time and sequence the walker's start/busy pair.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_req           raw asynchronous button levels
//   i_busy          walker busy flag (i_clk domain)
//   o_start         one-cycle start pulse to the walker
//   o_grant         one-hot owner of the current walk, zero when idle
//   o_grant_id      index of the last granted requester
//   o_pending       latched requests not yet granted
//   o_active        high whenever the scheduler is not idle
module walk_req_scheduler
  import walk_sched_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_REQ-1:0]         i_req,
  input  logic                     i_busy,
  output logic                     o_start,
  output logic [N_REQ-1:0]         o_grant,
  output logic [$clog2(N_REQ)-1:0] o_grant_id,
  output logic [N_REQ-1:0]         o_pending,
  output logic                     o_active
);

  localparam int IW   = $clog2(N_REQ);
  localparam int TMAX = max_int(BUSY_TIMEOUT, GAP_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] BUSY_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] T_SAT     = TW'(TMAX);
  localparam logic [IW-1:0] PTR_RST   = IW'(N_REQ - 1);

  logic [N_REQ-1:0] sync1_q, sync2_q, last_q;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [N_REQ-1:0] rise, clr;

  state_t           state_q;
  logic [N_REQ-1:0] grant_q;
  logic [IW-1:0]    ptr_q;
  logic             start_q;
  logic [TW-1:0]    tmr_q, tmr_inc;

  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic             take;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_pending (pend_q),
    .i_ptr     (ptr_q),
    .o_grant   (arb_grant),
    .o_idx     (arb_idx),
    .o_any     (arb_any)
  );

  assign rise = sync2_q & ~last_q;
  // A walker already running elsewhere blocks new grants from IDLE.
  assign take = (state_q == IDLE) && arb_any && !i_busy;
  assign clr  = take ? arb_grant : '0;
  // Set after clear: an edge coinciding with the grant re-queues the request.
  assign pend_d  = (pend_q & ~clr) | rise;
  assign tmr_inc = (tmr_q == T_SAT) ? tmr_q : tmr_q + TW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      last_q  <= '0;
      pend_q  <= '0;
    end else begin
      sync1_q <= i_req;
      sync2_q <= sync1_q;
      last_q  <= sync2_q;
      pend_q  <= pend_d;
    end
  end

  // The round-robin pointer doubles as o_grant_id: both always hold the last winner.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
      start_q <= 1'b0;
      tmr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take) begin
            state_q <= START;
            grant_q <= arb_grant;
            ptr_q   <= arb_idx;
            start_q <= 1'b1;
          end
        end
        START: begin
          state_q <= WAIT_BUSY;
          start_q <= 1'b0;
          tmr_q   <= '0;
        end
        WAIT_BUSY: begin
          if (i_busy) begin
            state_q <= RUN;
          end else if (tmr_q == BUSY_LAST) begin
            // Walker never answered: abandon this grant without re-queueing.
            state_q <= GAP;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_inc;
          end
        end
        RUN: begin
          if (!i_busy) begin
            state_q <= GAP;
            tmr_q   <= '0;
          end
        end
        GAP: begin
          if (tmr_q == GAP_LAST) begin
            state_q <= IDLE;
            grant_q <= '0;
          end else begin
            tmr_q <= tmr_inc;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          start_q <= 1'b0;
          tmr_q   <= '0;
        end
      endcase
    end
  end

  assign o_start    = start_q;
  assign o_grant    = grant_q;
  assign o_grant_id = ptr_q;
  assign o_pending  = pend_q;
  assign o_active   = (state_q != IDLE);

endmodule
